uart_tx: RTL and testbench
==========================

// Module: uart_tx
//
// PURPOSE
//  UART transmitter: the transmit-side counterpart of the team's uart_rx.
//  - Serialises one PAYLOAD_BITS word per request onto uart_txd.
//  - Frame format: 1 start bit (low), data LSB first, STOP_BITS stop bits (high).
//  - Bit timing is identical to uart_rx, so the two ends interoperate at the same parameters.
//  - Sits between the system-side byte producer and the off-chip TX pin.
//
// PARAMETERS
//  CYCLES_PER_BIT  5000  clk cycles per serial bit; must be >= 2
//  PAYLOAD_BITS    8     data bits per frame, 5..8
//  STOP_BITS       1     stop bits per frame, 1 or 2
//  COUNT_REG_LEN   14    cycle-counter width; must hold CYCLES_PER_BIT-1
//
// PORTS
//  clk             in   1             top-level system clock
//  resetn          in   1             asynchronous active-low reset
//  uart_txd        out  1             UART transmit pin; idle high
//  uart_tx_busy    out  1             high while a frame (or break) is in progress
//  uart_tx_en      in   1             send request; sampled only when busy is low
//  uart_tx_data    in   PAYLOAD_BITS  word to send; captured on the accept edge
//  uart_tx_break   in   1             break request; present only with UART_TX_BREAK_EN
//
// BEHAVIOUR
//  - Reset (async, resetn=0):
//    - Output values: uart_txd=1, uart_tx_busy=0.
//    - Internal state: FSM=IDLE; cycle counter, bit counter and shift register cleared.
//    - Mid-frame reset aborts the frame; txd goes high immediately, without waiting for a clock.
//  - Accept: at a posedge with state IDLE and uart_tx_en=1.
//    - uart_tx_data is latched into the shift register.
//    - The next cycle shows txd=0 (start bit) and busy=1.
//  - No queuing:
//    - uart_tx_en while busy=1 is ignored and the word is dropped.
//    - uart_tx_data changes after the accept edge have no effect.
//  - FSM (registered; txd and busy are registered outputs, no combinational path from inputs):
//    - IDLE  : txd=1. Goes to START on accept (or to BREAK, see CONFIGURATION).
//    - START : txd=0 for CYCLES_PER_BIT cycles, then SEND.
//    - SEND  : txd=shift[0] for CYCLES_PER_BIT cycles per bit; shift right at each bit end;
//              after PAYLOAD_BITS bits go to STOP.
//    - STOP  : txd=1 for STOP_BITS*CYCLES_PER_BIT cycles, then IDLE.
//  - Counters:
//    - The cycle counter counts 0..CYCLES_PER_BIT-1 and wraps to 0 at each bit boundary.
//    - It is held at 0 in IDLE.
//    - The bit counter is cleared on entry to each state that uses it.
//  - Frame length: exactly (1+PAYLOAD_BITS+STOP_BITS)*CYCLES_PER_BIT cycles with busy=1.
//  - Back-to-back frames:
//    - busy falls on the cycle after the last stop-bit cycle.
//    - uart_tx_en high at that edge is accepted.
//    - Minimum gap between frames is 1 idle cycle with txd=1.
//
// CONFIGURATION
//  - Macro UART_TX_BREAK_EN defined:
//    - Input uart_tx_break exists and the FSM adds a BREAK state.
//    - Entry: from IDLE when uart_tx_break=1.
//    - BREAK has priority over uart_tx_en when both are high in the same cycle; the en
//      request is dropped.
//    - BREAK drives txd=0 for (1+PAYLOAD_BITS+STOP_BITS)*CYCLES_PER_BIT cycles, then enters
//      STOP (txd=1 for STOP_BITS bit times), then IDLE.
//    - busy=1 throughout BREAK and its STOP.
//    - uart_rx reports the result as uart_rx_break.
//  - Macro undefined: the port is absent, there is no BREAK state, and behaviour is exactly
//    as above.
//
// TESTING  (sim overrides CYCLES_PER_BIT=8, PAYLOAD_BITS=8, STOP_BITS=1; frame = 80 cycles)
//  - Reset check: resetn=0 -> txd=1, busy=0. Release, hold en=0 for 100 cycles
//    -> txd stays 1, busy stays 0.
//  - Single frame: en=1 for 1 cycle with data=8'hA5 -> txd bits 0,1,0,1,0,0,1,0,1,1,
//    each 8 cycles; busy=1 for 80 cycles. A looped-back uart_rx yields 8'hA5.
//  - Busy drop: data=8'h3C accepted; pulse en with 8'hFF at cycle 20
//    -> only the 8'h3C frame is sent; no second frame follows.
//  - Back-to-back: hold en=1 with 8'h00 then 8'hFF -> 2 frames separated by exactly
//    1 idle-high cycle.
//  - Reset mid-frame: assert resetn=0 at cycle 35 of a frame -> txd=1 and busy=0
//    asynchronously; the next accepted frame is bit-exact.
//  - Break (UART_TX_BREAK_EN): break=1 and en=1 together -> txd=0 for 80 cycles, then 1
//    for 8 cycles, busy=1 for 88 cycles; uart_rx flags a break.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// UART transmitter. It sends one PAYLOAD_BITS word per accepted request on
// uart_txd. Each frame is one low start bit, the data LSB first, and
// STOP_BITS high stop bits. Every bit lasts CYCLES_PER_BIT clk cycles, which
// is the same bit timing that uart_rx uses.
//
// Optional feature: define UART_TX_BREAK_EN to add the uart_tx_break input
// and a BREAK state. That state holds the line low for one whole frame time,
// then sends the normal stop bits.
//
// Ports
//   clk            in   system clock
//   resetn         in   asynchronous active-low reset
//   uart_txd       out  serial output, idle high (registered)
//   uart_tx_busy   out  high while a frame or break is on the line (registered)
//   uart_tx_en     in   send request, sampled only while idle
//   uart_tx_data   in   word to send, captured on the accept edge
//   uart_tx_break  in   break request (only with UART_TX_BREAK_EN)
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CYCLES_PER_BIT = 5000,
    parameter int PAYLOAD_BITS   = 8,
    parameter int STOP_BITS      = 1,
    parameter int COUNT_REG_LEN  = 14
) (
    input  logic                    clk,
    input  logic                    resetn,
    output logic                    uart_txd,
    output logic                    uart_tx_busy,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data
`ifdef UART_TX_BREAK_EN
    ,
    input  logic                    uart_tx_break
`endif
);

    // The bit counter has to reach the break length, which is at most
    // 1 + 8 + 2 = 11 bit times. Four bits are enough for that.
    localparam int BIT_CNT_W = 4;

    localparam logic [COUNT_REG_LEN-1:0] CYCLE_LAST = COUNT_REG_LEN'(CYCLES_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0]     DATA_LAST  = BIT_CNT_W'(PAYLOAD_BITS - 1);
    localparam logic [BIT_CNT_W-1:0]     STOP_LAST  = BIT_CNT_W'(STOP_BITS - 1);
    localparam logic [BIT_CNT_W-1:0]     BREAK_LAST = BIT_CNT_W'(PAYLOAD_BITS + STOP_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SEND,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                   state_reg, state_next;
    logic [COUNT_REG_LEN-1:0] cycle_cnt_reg, cycle_cnt_next;
    logic [BIT_CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [PAYLOAD_BITS-1:0]  shift_reg, shift_next;
    logic                     txd_reg, txd_next;
    logic                     busy_reg, busy_next;
    logic                     bit_end;

    assign bit_end = (cycle_cnt_reg == CYCLE_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= S_IDLE;
            cycle_cnt_reg <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            txd_reg       <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cycle_cnt_reg <= cycle_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            txd_reg       <= txd_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cycle_cnt_next = cycle_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;

        // Every state except IDLE times its bits with the same cycle counter.
        // The counter wraps at each bit boundary.
        if (state_reg != S_IDLE) begin
            cycle_cnt_next = bit_end ? '0 : cycle_cnt_reg + 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                cycle_cnt_next = '0;
                bit_cnt_next   = '0;
`ifdef UART_TX_BREAK_EN
                // A break wins over a send request in the same cycle.
                // The send request is dropped.
                if (uart_tx_break) begin
                    state_next = S_BREAK;
                end else
`endif
                if (uart_tx_en) begin
                    state_next = S_START;
                    shift_next = uart_tx_data;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_next   = S_SEND;
                    bit_cnt_next = '0;
                end
            end

            S_SEND: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt_reg == DATA_LAST) begin
                        state_next   = S_STOP;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_reg == STOP_LAST) begin
                        state_next = S_IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end

`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                if (bit_end) begin
                    if (bit_cnt_reg == BREAK_LAST) begin
                        state_next   = S_STOP;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
`endif

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The line level is computed from the next state, so the registered
    // outputs match the state register on the same cycle. No input reaches
    // the pins without passing through a flop.
    always_comb begin
        txd_next  = 1'b1;
        busy_next = (state_next != S_IDLE);
        case (state_next)
            S_START: txd_next = 1'b0;
            S_SEND:  txd_next = shift_next[0];
            S_BREAK: txd_next = 1'b0;
            default: txd_next = 1'b1;
        endcase
    end

    assign uart_txd     = txd_reg;
    assign uart_tx_busy = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Directed bench for uart_tx with 8 cycles per bit, 8 data bits and 1 stop
// bit, so one frame is 80 cycles. The outputs are logged on every falling
// clock edge. Each frame is then checked bit by bit against hand-derived
// line levels.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CPB   = 8;
    localparam int FRAME = 80;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       uart_txd;
    logic       uart_tx_busy;
    logic       uart_tx_en = 1'b0;
    logic [7:0] uart_tx_data = 8'h00;
`ifdef UART_TX_BREAK_EN
    logic       uart_tx_break = 1'b0;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic txd_log[$];
    logic busy_log[$];

    always #5 clk = ~clk;

    uart_tx #(
        .CYCLES_PER_BIT(CPB),
        .PAYLOAD_BITS  (8),
        .STOP_BITS     (1),
        .COUNT_REG_LEN (14)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .uart_txd     (uart_txd),
        .uart_tx_busy (uart_tx_busy),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data)
`ifdef UART_TX_BREAK_EN
        ,
        .uart_tx_break(uart_tx_break)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Wait for one falling edge, then log the outputs. Stimulus changes are
    // made right after this returns, so the next rising edge sees them.
    task automatic tick();
        @(negedge clk);
        txd_log.push_back(uart_txd);
        busy_log.push_back(uart_tx_busy);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_log();
        txd_log  = {};
        busy_log = {};
    endtask

    function automatic logic log_txd(input int idx);
        return (idx < txd_log.size()) ? txd_log[idx] : 1'bx;
    endfunction

    function automatic logic log_busy(input int idx);
        return (idx < busy_log.size()) ? busy_log[idx] : 1'bx;
    endfunction

    // Check one frame that starts at log index s. Every bit time must be
    // flat at the expected level. The busy run must last one frame. Sampling
    // in the middle of each bit must give back the word that was sent.
    task automatic check_frame(input string tag, input int s, input logic [7:0] data);
        logic [7:0] samp;
        logic [7:0] dec;
        logic       lvl;
        int         n;
        for (int i = 0; i < 10; i++) begin
            lvl = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : data[i-1];
            for (int k = 0; k < CPB; k++) samp[k] = log_txd(s + i * CPB + k);
            check($sformatf("%s_bit%0d", tag, i), {24'd0, samp}, lvl ? 32'hFF : 32'h00);
        end
        for (int i = 0; i < 8; i++) dec[i] = log_txd(s + (i + 1) * CPB + CPB / 2);
        check($sformatf("%s_data", tag), {24'd0, dec}, {24'd0, data});
        n = 0;
        while ((s + n) < busy_log.size() && busy_log[s + n] === 1'b1) n++;
        check($sformatf("%s_busy_len", tag), n, FRAME);
    endtask

    function automatic int count_busy(input int from);
        int n = 0;
        for (int i = from; i < busy_log.size(); i++) if (busy_log[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_low(input int from);
        int n = 0;
        for (int i = from; i < txd_log.size(); i++) if (txd_log[i] !== 1'b1) n++;
        return n;
    endfunction

    initial begin
        // Reset state, applied between clock edges.
        #2 resetn = 1'b0;
        #1;
        check("reset_txd", uart_txd, 1);
        check("reset_busy", uart_tx_busy, 0);
        run(3);
        resetn = 1'b1;

        // Line stays idle with no request.
        clear_log();
        run(100);
        check("idle_busy_cycles", count_busy(0), 0);
        check("idle_low_cycles", count_low(0), 0);

        // Single frame 0xA5. The data input changes after accept and must
        // not affect the frame.
        clear_log();
        uart_tx_en = 1'b1; uart_tx_data = 8'hA5;
        tick();
        uart_tx_en = 1'b0; uart_tx_data = 8'h3F;
        run(99);
        check_frame("a5", 0, 8'hA5);
        check("a5_after_busy", log_busy(FRAME), 0);

        // Request while busy is dropped.
        clear_log();
        uart_tx_en = 1'b1; uart_tx_data = 8'h3C;
        tick();
        uart_tx_en = 1'b0;
        run(19);
        uart_tx_en = 1'b1; uart_tx_data = 8'hFF;
        tick();
        uart_tx_en = 1'b0;
        run(179);
        check_frame("drop", 0, 8'h3C);
        check("drop_total_busy", count_busy(0), FRAME);
        check("drop_no_second", count_low(FRAME), 0);

        // Back-to-back frames with en held high.
        clear_log();
        uart_tx_en = 1'b1; uart_tx_data = 8'h00;
        tick();
        uart_tx_data = 8'hFF;
        run(81);
        uart_tx_en = 1'b0;
        run(100);
        check_frame("b2b0", 0, 8'h00);
        check("b2b_gap_txd", log_txd(FRAME), 1);
        check("b2b_gap_busy", log_busy(FRAME), 0);
        check_frame("b2b1", FRAME + 1, 8'hFF);
        check("b2b_total_busy", count_busy(0), 2 * FRAME);

        // Reset in the middle of a frame. Cycle 35 falls inside data bit 3
        // of 0x96, which is low, so the line has to jump high.
        clear_log();
        uart_tx_en = 1'b1; uart_tx_data = 8'h96;
        tick();
        uart_tx_en = 1'b0;
        run(34);
        check("mid_pre_txd", log_txd(34), 0);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_txd", uart_txd, 1);
        check("mid_rst_busy", uart_tx_busy, 0);
        run(2);
        resetn = 1'b1;
        tick();
        clear_log();
        uart_tx_en = 1'b1; uart_tx_data = 8'h5A;
        tick();
        uart_tx_en = 1'b0;
        run(99);
        check_frame("post", 0, 8'h5A);

`ifdef UART_TX_BREAK_EN
        // A break together with en: 10 bit times low, 1 stop bit high,
        // and the en request is dropped.
        clear_log();
        uart_tx_break = 1'b1; uart_tx_en = 1'b1; uart_tx_data = 8'h55;
        tick();
        uart_tx_break = 1'b0; uart_tx_en = 1'b0;
        run(119);
        begin
            logic [7:0] samp;
            int         n;
            for (int i = 0; i < 11; i++) begin
                for (int k = 0; k < CPB; k++) samp[k] = log_txd(i * CPB + k);
                check($sformatf("brk_bit%0d", i), {24'd0, samp}, (i == 10) ? 32'hFF : 32'h00);
            end
            n = 0;
            while (n < busy_log.size() && busy_log[n] === 1'b1) n++;
            check("brk_busy_len", n, FRAME + CPB);
            check("brk_no_frame", count_low(FRAME + CPB), 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
